rf_wb_scheduler: RTL and testbench
==================================

Name: rf_wb_scheduler

Overview:
- Write-back scheduler and scoreboard for the 8 x 16-bit register file (r0 reads as zero).
- Shares the file's single write port between two producers, ALU and memory-load, using valid/ready handshakes.
- Drives the port's enable/wr_reg/wr_data from registers.
- Tracks per-register pending writes and stalls issue on RAW/WAW hazards.

Parameters:
- DATA_W, 16, write-data width.
- ADDR_W, 3, register-address width.
- NREG, 8, number of registers (2**ADDR_W).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- iss_valid  in  1  decode presents an instruction.
- iss_rs1  in  ADDR_W  source register 1.
- iss_rs2  in  ADDR_W  source register 2.
- iss_rd  in  ADDR_W  destination register.
- iss_uses_rd  in  1  instruction writes iss_rd.
- iss_stall  out  1  combinational; hold the instruction.
- alu_valid  in  1  ALU result available.
- alu_ready  out  1  ALU result accepted this cycle.
- alu_rd  in  ADDR_W  ALU destination.
- alu_data  in  DATA_W  ALU result.
- mem_valid  in  1  load result available.
- mem_ready  out  1  load result accepted this cycle.
- mem_rd  in  ADDR_W  load destination.
- mem_data  in  DATA_W  load data.
- rf_wr_en  out  1  register-file write enable (registered).
- rf_wr_reg  out  ADDR_W  register-file write address (registered).
- rf_wr_data  out  DATA_W  register-file write data (registered).
- busy_vec  out  NREG  scoreboard, bit r = write to r pending.

Behaviour:
Reset:
- Async on rst_n low: rf_wr_en=0, rf_wr_reg=0, rf_wr_data=0, busy_vec=0, round-robin pointer = ALU.
- Reset mid-operation discards in-flight grants and pending busy bits.

Arbitration:
- alu_ready/mem_ready are combinational, and at most one is high per cycle.
- Exactly one valid producer: that producer is granted.
- Both valid: the producer named by the RR pointer is granted; the pointer then moves to the other producer.
- The pointer updates only on contention.
- Not granted: the producer must hold valid, rd and data stable until ready.

Write path:
- Handshake in cycle N latches rd/data into rf_wr_reg/rf_wr_data.
- rf_wr_en=1 in cycle N+1 for one cycle. Latency is 1 cycle, with one write per cycle sustained.
- rd=0: handshake completes, but rf_wr_en stays 0 in N+1 (write dropped).
- No handshake in N: rf_wr_en=0 in N+1; rf_wr_reg/rf_wr_data hold their last values.

Scoreboard:
- Issue accept = iss_valid & ~iss_stall.
- On accept with iss_uses_rd=1 and iss_rd!=0, busy[iss_rd] is set at the next edge.
- busy[r] clears on the edge ending the cycle in which rf_wr_en=1 and rf_wr_reg=r. The file therefore holds the new value before a dependent instruction reads it.
- Same-edge set and clear of the same r: set wins (a new producer is in flight).
- Write-back to a non-busy register is still written; the scoreboard is unchanged.
- busy[0] is always 0.

Stall:
- iss_stall = iss_valid & (busy[rs1] | busy[rs2] | (iss_uses_rd & busy[rd])).
- rs=0 never stalls.
- iss_valid=0 gives iss_stall=0.

Optional Feature:
- Macro: RF_WB_FIXED_PRIO_EN.
- Defined: ALU always wins contention, the memory producer is granted only when alu_valid=0, and there is no RR pointer register.
- Undefined: round-robin as described above.
- Reset values and the write path are identical in both builds.

Decomposition:
- Package rf_pkg: DATA_W/ADDR_W/NREG constants, a reg_addr_t typedef (ADDR_W bits), a wb_req_t struct {rd, data}, and the constant R0 = 0.
- Sub-module rf_scoreboard: busy vector set/clear plus stall compare.
- The arbiter and write register stay in the top.

Test Plan:
- Reset, then alu_valid=1, rd=3, data=16'hBEEF, in cycle N: alu_ready=1 in N; in N+1 rf_wr_en=1, rf_wr_reg=3, rf_wr_data=16'hBEEF; in N+2 rf_wr_en=0.
- alu_valid and mem_valid held 1 for 4 cycles (rd 1/2): grants alternate ALU, MEM, ALU, MEM. With RF_WB_FIXED_PRIO_EN defined: ALU granted all 4 cycles, mem_ready=0.
- Issue rd=5 accepted: busy_vec=8'h20 next cycle. Issue with rs1=5: iss_stall=1 until the edge after rf_wr_en=1 with rf_wr_reg=5, then 0.
- Issue rd=0 and ALU write-back rd=0 data=16'h1234: busy_vec stays 0, rf_wr_en never asserts, alu_ready=1.
- In the cycle rf_wr_en=1 with rf_wr_reg=6, a new issue with rd=6 is accepted: busy[6]=1 afterwards (set wins).
- rst_n pulsed low mid-stream with busy_vec=8'h0C and a grant in flight: immediately busy_vec=0, rf_wr_en=0; after release the first grant goes to ALU.

Source files
------------

// File: rtl/rf_pkg.sv
// rtl/rf_pkg.sv - shared constants and types for the register-file write-back scheduler
package rf_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int NREG   = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;

    // One pending write-back request as presented by a producer
    typedef struct packed {
        reg_addr_t         rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Round-robin pointer: which producer wins the next contention
    typedef enum logic {
        PROD_ALU = 1'b0,
        PROD_MEM = 1'b1
    } prod_t;

    localparam reg_addr_t R0 = '0;

endpackage

// File: rtl/rf_wb_scheduler_if.sv
// rtl/rf_wb_scheduler_if.sv - issue, producer and register-file write bundle for the scheduler
interface rf_wb_if;
    import rf_pkg::*;

    logic              iss_valid;
    reg_addr_t         iss_rs1;
    reg_addr_t         iss_rs2;
    reg_addr_t         iss_rd;
    logic              iss_uses_rd;
    logic              iss_stall;

    logic              alu_valid;
    logic              alu_ready;
    reg_addr_t         alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    reg_addr_t         mem_rd;
    logic [DATA_W-1:0] mem_data;

    logic              rf_wr_en;
    reg_addr_t         rf_wr_reg;
    logic [DATA_W-1:0] rf_wr_data;
    logic [NREG-1:0]   busy_vec;

    // Decode, producers and register file side
    modport master (
        output iss_valid, iss_rs1, iss_rs2, iss_rd, iss_uses_rd,
        output alu_valid, alu_rd, alu_data,
        output mem_valid, mem_rd, mem_data,
        input  iss_stall, alu_ready, mem_ready,
        input  rf_wr_en, rf_wr_reg, rf_wr_data, busy_vec
    );

    // Scheduler side
    modport slave (
        input  iss_valid, iss_rs1, iss_rs2, iss_rd, iss_uses_rd,
        input  alu_valid, alu_rd, alu_data,
        input  mem_valid, mem_rd, mem_data,
        output iss_stall, alu_ready, mem_ready,
        output rf_wr_en, rf_wr_reg, rf_wr_data, busy_vec
    );

endinterface

// File: rtl/rf_scoreboard.sv
// rtl/rf_scoreboard.sv - per-register pending-write tracking and RAW/WAW issue stall
module rf_scoreboard
    import rf_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iss_valid,
    input  reg_addr_t       iss_rs1,
    input  reg_addr_t       iss_rs2,
    input  reg_addr_t       iss_rd,
    input  logic            iss_uses_rd,
    input  logic            wb_en,
    input  reg_addr_t       wb_reg,
    output logic            iss_stall,
    output logic [NREG-1:0] busy_vec
);

    localparam logic [NREG-1:0] R0_MASK = NREG'(1);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;
    logic            accept;

    // Stall on any pending source or destination; set is ORed after clear so a new producer wins
    always_comb begin
        iss_stall = iss_valid & (busy_q[iss_rs1] | busy_q[iss_rs2] |
                                 (iss_uses_rd & busy_q[iss_rd]));
        accept    = iss_valid & ~iss_stall;
        set_mask  = (accept & iss_uses_rd & (iss_rd != R0)) ? (NREG'(1) << iss_rd) : '0;
        clr_mask  = wb_en ? (NREG'(1) << wb_reg) : '0;
        busy_d    = ((busy_q & ~clr_mask) | set_mask) & ~R0_MASK;
    end

    // Scoreboard state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/rf_wb_scheduler.sv
// rtl/rf_wb_scheduler.sv - write-port arbiter, registered write stage and scoreboard; RF_WB_FIXED_PRIO_EN selects ALU-first priority
module rf_wb_scheduler
    import rf_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    rf_wb_if.slave  bus
);

    logic              grant_alu;
    logic              grant_mem;
    wb_req_t           req;

    logic              wr_en_q,   wr_en_d;
    reg_addr_t         wr_reg_q,  wr_reg_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

`ifdef RF_WB_FIXED_PRIO_EN
    // ALU always wins; memory only gets the port when the ALU is idle
    always_comb begin
        grant_alu = bus.alu_valid;
        grant_mem = bus.mem_valid & ~bus.alu_valid;
    end
`else
    prod_t rr_q, rr_d;

    // Round-robin grant; pointer only moves when both producers contend
    always_comb begin
        grant_alu = bus.alu_valid & (~bus.mem_valid | (rr_q == PROD_ALU));
        grant_mem = bus.mem_valid & ~grant_alu;
        rr_d      = rr_q;
        if (bus.alu_valid && bus.mem_valid) begin
            rr_d = grant_alu ? PROD_MEM : PROD_ALU;
        end
    end

    // Round-robin pointer register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_q <= PROD_ALU;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign bus.alu_ready = grant_alu;
    assign bus.mem_ready = grant_mem;

    // Winning request; writes to r0 complete the handshake but never enable the port
    always_comb begin
        req       = '{rd: bus.alu_rd, data: bus.alu_data};
        if (grant_mem) begin
            req   = '{rd: bus.mem_rd, data: bus.mem_data};
        end
        wr_en_d   = 1'b0;
        wr_reg_d  = wr_reg_q;
        wr_data_d = wr_data_q;
        if (grant_alu || grant_mem) begin
            wr_en_d   = (req.rd != R0);
            wr_reg_d  = req.rd;
            wr_data_d = req.data;
        end
    end

    // Registered register-file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q   <= 1'b0;
            wr_reg_q  <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_reg_q  <= wr_reg_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.rf_wr_en   = wr_en_q;
    assign bus.rf_wr_reg  = wr_reg_q;
    assign bus.rf_wr_data = wr_data_q;

    rf_scoreboard u_scoreboard (
        .clk         (clk),
        .rst_n       (rst_n),
        .iss_valid   (bus.iss_valid),
        .iss_rs1     (bus.iss_rs1),
        .iss_rs2     (bus.iss_rs2),
        .iss_rd      (bus.iss_rd),
        .iss_uses_rd (bus.iss_uses_rd),
        .wb_en       (wr_en_q),
        .wb_reg      (wr_reg_q),
        .iss_stall   (bus.iss_stall),
        .busy_vec    (bus.busy_vec)
    );

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// tb/tb_rf_wb_scheduler.sv - self-checking bench for rf_wb_scheduler with directed scenarios and a random reference-model run
module tb_rf_wb_scheduler;
    import rf_pkg::*;

`ifdef RF_WB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    rf_wb_if bus();

    rf_wb_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want finish");
        $fatal(1);
    end

    task automatic idle_inputs();
        bus.iss_valid = 1'b0; bus.iss_rs1 = '0; bus.iss_rs2 = '0; bus.iss_rd = '0; bus.iss_uses_rd = 1'b0;
        bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
        bus.mem_valid = 1'b0; bus.mem_rd = '0; bus.mem_data = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        #12;
        n_cmp++; if (bus.rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL reset_wr_en: got %b want 0", bus.rf_wr_en); end
        n_cmp++; if (bus.rf_wr_reg !== 3'd0) begin n_bad++; $display("FAIL reset_wr_reg: got %0d want 0", bus.rf_wr_reg); end
        n_cmp++; if (bus.rf_wr_data !== 16'h0) begin n_bad++; $display("FAIL reset_wr_data: got %h want 0000", bus.rf_wr_data); end
        n_cmp++; if (bus.busy_vec !== 8'h00) begin n_bad++; $display("FAIL reset_busy: got %h want 00", bus.busy_vec); end
        n_cmp++; if (bus.iss_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", bus.iss_stall); end
        n_cmp++; if ({bus.alu_ready, bus.mem_ready} !== 2'b00) begin n_bad++; $display("FAIL reset_ready: got %b want 00", {bus.alu_ready, bus.mem_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd3; bus.alu_data = 16'hBEEF;
        #1;
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL single_alu_ready: got %b want 1", bus.alu_ready); end
        n_cmp++; if (bus.mem_ready !== 1'b0) begin n_bad++; $display("FAIL single_mem_ready: got %b want 0", bus.mem_ready); end
        @(posedge clk); #1;
        n_cmp++; if (bus.rf_wr_en !== 1'b1) begin n_bad++; $display("FAIL single_wr_en_n1: got %b want 1", bus.rf_wr_en); end
        n_cmp++; if (bus.rf_wr_reg !== 3'd3) begin n_bad++; $display("FAIL single_wr_reg: got %0d want 3", bus.rf_wr_reg); end
        n_cmp++; if (bus.rf_wr_data !== 16'hBEEF) begin n_bad++; $display("FAIL single_wr_data: got %h want beef", bus.rf_wr_data); end
        @(negedge clk);
        bus.alu_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if (bus.rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL single_wr_en_n2: got %b want 0", bus.rf_wr_en); end
        n_cmp++; if (bus.rf_wr_data !== 16'hBEEF) begin n_bad++; $display("FAIL single_data_hold: got %h want beef", bus.rf_wr_data); end
    endtask

    task automatic test_contention();
        bit exp_alu;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'hA001;
            bus.mem_valid = 1'b1; bus.mem_rd = 3'd2; bus.mem_data = 16'hB002;
            exp_alu = FIXED ? 1'b1 : ((k % 2) == 0);
            #1;
            n_cmp++; if (bus.alu_ready !== exp_alu) begin n_bad++; $display("FAIL contend_alu_ready[%0d]: got %b want %b", k, bus.alu_ready, exp_alu); end
            n_cmp++; if (bus.mem_ready !== !exp_alu) begin n_bad++; $display("FAIL contend_mem_ready[%0d]: got %b want %b", k, bus.mem_ready, !exp_alu); end
            @(posedge clk); #1;
            n_cmp++; if (bus.rf_wr_reg !== (exp_alu ? 3'd1 : 3'd2)) begin n_bad++; $display("FAIL contend_wr_reg[%0d]: got %0d want %0d", k, bus.rf_wr_reg, exp_alu ? 1 : 2); end
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_scoreboard_stall();
        @(negedge clk);
        idle_inputs();
        bus.iss_valid = 1'b1; bus.iss_uses_rd = 1'b1; bus.iss_rd = 3'd5;
        #1;
        n_cmp++; if (bus.iss_stall !== 1'b0) begin n_bad++; $display("FAIL sb_first_stall: got %b want 0", bus.iss_stall); end
        @(posedge clk); #1;
        n_cmp++; if (bus.busy_vec !== 8'h20) begin n_bad++; $display("FAIL sb_busy_set: got %h want 20", bus.busy_vec); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            bus.iss_uses_rd = 1'b0; bus.iss_rd = 3'd0; bus.iss_rs1 = 3'd5;
            #1;
            n_cmp++; if (bus.iss_stall !== 1'b1) begin n_bad++; $display("FAIL sb_raw_stall[%0d]: got %b want 1", k, bus.iss_stall); end
        end
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd5; bus.alu_data = 16'h5555;
        #1;
        n_cmp++; if (bus.iss_stall !== 1'b1) begin n_bad++; $display("FAIL sb_stall_at_grant: got %b want 1", bus.iss_stall); end
        @(negedge clk);
        bus.alu_valid = 1'b0;
        #1;
        n_cmp++; if ({bus.rf_wr_en, bus.rf_wr_reg} !== {1'b1, 3'd5}) begin n_bad++; $display("FAIL sb_wb_visible: got %b/%0d want 1/5", bus.rf_wr_en, bus.rf_wr_reg); end
        n_cmp++; if (bus.iss_stall !== 1'b1) begin n_bad++; $display("FAIL sb_stall_during_wb: got %b want 1", bus.iss_stall); end
        @(posedge clk); #1;
        n_cmp++; if (bus.busy_vec !== 8'h00) begin n_bad++; $display("FAIL sb_busy_clear: got %h want 00", bus.busy_vec); end
        n_cmp++; if (bus.iss_stall !== 1'b0) begin n_bad++; $display("FAIL sb_stall_release: got %b want 0", bus.iss_stall); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_r0();
        @(negedge clk);
        bus.iss_valid = 1'b1; bus.iss_uses_rd = 1'b1; bus.iss_rd = 3'd0;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd0; bus.alu_data = 16'h1234;
        #1;
        n_cmp++; if (bus.alu_ready !== 1'b1) begin n_bad++; $display("FAIL r0_alu_ready: got %b want 1", bus.alu_ready); end
        n_cmp++; if (bus.iss_stall !== 1'b0) begin n_bad++; $display("FAIL r0_stall: got %b want 0", bus.iss_stall); end
        @(posedge clk); #1;
        n_cmp++; if (bus.rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL r0_wr_en: got %b want 0", bus.rf_wr_en); end
        n_cmp++; if (bus.busy_vec !== 8'h00) begin n_bad++; $display("FAIL r0_busy: got %h want 00", bus.busy_vec); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_set_wins();
        do_reset();
        @(negedge clk);
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd6; bus.alu_data = 16'h6666;
        @(negedge clk);
        bus.alu_valid = 1'b0;
        bus.iss_valid = 1'b1; bus.iss_uses_rd = 1'b1; bus.iss_rd = 3'd6;
        #1;
        n_cmp++; if ({bus.rf_wr_en, bus.rf_wr_reg} !== {1'b1, 3'd6}) begin n_bad++; $display("FAIL setwin_wb: got %b/%0d want 1/6", bus.rf_wr_en, bus.rf_wr_reg); end
        n_cmp++; if (bus.iss_stall !== 1'b0) begin n_bad++; $display("FAIL setwin_stall: got %b want 0", bus.iss_stall); end
        @(posedge clk); #1;
        n_cmp++; if (bus.busy_vec !== 8'h40) begin n_bad++; $display("FAIL setwin_busy: got %h want 40", bus.busy_vec); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        bus.iss_valid = 1'b1; bus.iss_uses_rd = 1'b1; bus.iss_rd = 3'd2;
        @(negedge clk);
        bus.iss_rd = 3'd3;
        @(negedge clk);
        bus.iss_valid = 1'b0;
        bus.alu_valid = 1'b1; bus.alu_rd = 3'd1; bus.alu_data = 16'h0A0A;
        bus.mem_valid = 1'b1; bus.mem_rd = 3'd4; bus.mem_data = 16'h0B0B;
        @(negedge clk);
        #1;
        n_cmp++; if (bus.busy_vec !== 8'h0C) begin n_bad++; $display("FAIL midrst_busy_before: got %h want 0c", bus.busy_vec); end
        n_cmp++; if (bus.mem_ready !== !FIXED) begin n_bad++; $display("FAIL midrst_mem_grant: got %b want %b", bus.mem_ready, !FIXED); end
        n_cmp++; if (bus.rf_wr_en !== 1'b1) begin n_bad++; $display("FAIL midrst_en_before: got %b want 1", bus.rf_wr_en); end
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.busy_vec !== 8'h00) begin n_bad++; $display("FAIL midrst_busy: got %h want 00", bus.busy_vec); end
        n_cmp++; if (bus.rf_wr_en !== 1'b0) begin n_bad++; $display("FAIL midrst_en: got %b want 0", bus.rf_wr_en); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_cmp++; if ({bus.alu_ready, bus.mem_ready} !== 2'b10) begin n_bad++; $display("FAIL midrst_first_grant: got %b want 10", {bus.alu_ready, bus.mem_ready}); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        logic [NREG-1:0]   m_busy;
        bit                m_mem_turn;
        logic              m_en;
        reg_addr_t         m_reg;
        logic [DATA_W-1:0] m_data;
        bit                a_pend, b_pend, alu_tie, e_alu, e_mem, e_stall;
        reg_addr_t         a_rd, b_rd;
        logic [DATA_W-1:0] a_dat, b_dat;
        do_reset();
        m_busy = '0; m_mem_turn = 1'b0; m_en = 1'b0; m_reg = '0; m_data = '0;
        a_pend = 1'b0; b_pend = 1'b0; a_rd = '0; b_rd = '0; a_dat = '0; b_dat = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (!a_pend && $urandom_range(0, 2) != 0) begin a_pend = 1'b1; a_rd = 3'($urandom_range(0, 7)); a_dat = 16'($urandom); end
            if (!b_pend && $urandom_range(0, 2) != 0) begin b_pend = 1'b1; b_rd = 3'($urandom_range(0, 7)); b_dat = 16'($urandom); end
            bus.alu_valid = a_pend; bus.alu_rd = a_rd; bus.alu_data = a_dat;
            bus.mem_valid = b_pend; bus.mem_rd = b_rd; bus.mem_data = b_dat;
            bus.iss_valid = 1'($urandom_range(0, 1));
            bus.iss_rs1 = 3'($urandom_range(0, 7)); bus.iss_rs2 = 3'($urandom_range(0, 7));
            bus.iss_rd = 3'($urandom_range(0, 7)); bus.iss_uses_rd = 1'($urandom_range(0, 1));
            #1;
            alu_tie = FIXED ? 1'b1 : !m_mem_turn;
            e_alu   = a_pend && (!b_pend || alu_tie);
            e_mem   = b_pend && !e_alu;
            e_stall = bus.iss_valid && (m_busy[bus.iss_rs1] || m_busy[bus.iss_rs2] ||
                                        (bus.iss_uses_rd && m_busy[bus.iss_rd]));
            n_cmp++; if (bus.alu_ready !== e_alu) begin n_bad++; $display("FAIL rnd_alu_ready@%0d: got %b want %b", cyc, bus.alu_ready, e_alu); end
            n_cmp++; if (bus.mem_ready !== e_mem) begin n_bad++; $display("FAIL rnd_mem_ready@%0d: got %b want %b", cyc, bus.mem_ready, e_mem); end
            n_cmp++; if (bus.iss_stall !== e_stall) begin n_bad++; $display("FAIL rnd_stall@%0d: got %b want %b", cyc, bus.iss_stall, e_stall); end
            n_cmp++; if (bus.busy_vec !== m_busy) begin n_bad++; $display("FAIL rnd_busy@%0d: got %h want %h", cyc, bus.busy_vec, m_busy); end
            n_cmp++; if ({bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data} !== {m_en, m_reg, m_data}) begin
                n_bad++; $display("FAIL rnd_wrport@%0d: got %b/%0d/%h want %b/%0d/%h", cyc, bus.rf_wr_en, bus.rf_wr_reg, bus.rf_wr_data, m_en, m_reg, m_data);
            end
            if (m_en) m_busy[m_reg] = 1'b0;
            if (bus.iss_valid && !e_stall && bus.iss_uses_rd && bus.iss_rd != 3'd0) m_busy[bus.iss_rd] = 1'b1;
            if (a_pend && b_pend && !FIXED) m_mem_turn = !m_mem_turn;
            if (e_alu) begin m_en = (a_rd != 3'd0); m_reg = a_rd; m_data = a_dat; a_pend = 1'b0; end
            else if (e_mem) begin m_en = (b_rd != 3'd0); m_reg = b_rd; m_data = b_dat; b_pend = 1'b0; end
            else m_en = 1'b0;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_scoreboard_stall();
        test_r0();
        test_set_wins();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
